// File: rtl/waveform_pkg.sv
// Constants shared by the waveform generators and their PWM back end.
package waveform_pkg;

  localparam int unsigned SAMPLE_W         = 8;
  localparam int unsigned PRESCALE_DEFAULT = 1;
  localparam int unsigned UCNT_W_DEFAULT   = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Width of a counter that holds 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_dac_tick_gen.sv
// Prescaler: one tick every PRESCALE enabled clocks; held at zero while disabled.
module pwm_tick_gen
  import waveform_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned    PW   = cnt_bits(PRESCALE);
  localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  assign tick = en && (presc == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (!en || (presc == LAST)) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// Sample-stream to single-bit PWM converter: one sample per 2^WIDTH-tick period,
// fed through a one-deep pending buffer, with underrun flagging and counting.
module pwm_dac
  import waveform_pkg::*;
#(
  parameter int unsigned WIDTH    = SAMPLE_W,
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
  parameter int unsigned UCNT_W   = UCNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              pwm_out,
  output logic              period_tick,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_count
);

  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [UCNT_W-1:0] UCNT_MAX = '1;

  logic             tick;
  logic             boundary_c;
  logic             accept_c;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] pending;
  logic             full;

  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign sample_ready = !full;
  assign accept_c     = sample_valid && !full;
  assign boundary_c   = tick && (cnt == CNT_MAX);

  // PWM position counter; a disabled converter restarts every period from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  // Pending buffer drains into duty only at a period boundary; accept never collides
  // with a drain because it requires the buffer to be empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      full    <= 1'b0;
      duty    <= '0;
    end else if (boundary_c && full) begin
      duty <= pending;
      full <= 1'b0;
    end else if (accept_c) begin
      pending <= sample_in;
      full    <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_tick    <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      period_tick <= boundary_c;
      underrun    <= boundary_c && !full;
      if (boundary_c && !full && (underrun_count != UCNT_MAX)) begin
        underrun_count <= underrun_count + UCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= en && (cnt < duty);
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac: period-level reference model plus arithmetic checks.
module tb_pwm_dac;

  logic       clk;
  logic       rst;

  logic       en, sample_valid, sample_ready, pwm_out, period_tick, underrun;
  logic [7:0] sample_in, underrun_count;

  logic       en4, sv4, sr4, pwm4, pt4, ur4;
  logic [7:0] sin4, uc4;

  logic       enw, svw, srw, pwmw, ptw, urw;
  logic [3:0] sinw;
  logic [7:0] ucw;

  int n_tests, n_fail;

  // reference model state for the main instance (WIDTH=8, PRESCALE=1)
  int m_k, m_duty, m_pend, m_ucnt, m_prev_duty;
  bit m_full, m_acc, e_pwm, e_pt, e_ur;

  pwm_dac #(.WIDTH(8), .PRESCALE(1), .UCNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .pwm_out(pwm_out), .period_tick(period_tick),
    .underrun(underrun), .underrun_count(underrun_count)
  );

  pwm_dac #(.WIDTH(8), .PRESCALE(4), .UCNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .sample_in(sin4), .sample_valid(sv4),
    .sample_ready(sr4), .pwm_out(pwm4), .period_tick(pt4),
    .underrun(ur4), .underrun_count(uc4)
  );

  pwm_dac #(.WIDTH(4), .PRESCALE(1), .UCNT_W(8)) dutw (
    .clk(clk), .rst(rst), .en(enw), .sample_in(sinw), .sample_valid(svw),
    .sample_ready(srw), .pwm_out(pwmw), .period_tick(ptw),
    .underrun(urw), .underrun_count(ucw)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_k = 0; m_duty = 0; m_pend = 0; m_ucnt = 0; m_full = 0; m_acc = 0; m_prev_duty = 0;
  endtask

  // Advance the main instance by one clock; model predicts outputs seen after the edge.
  task automatic step();
    int pos;
    bit bnd;
    bit acc;
    acc = sample_valid && !m_full;
    bnd = 0;
    if (en) begin
      pos   = m_k % 256;
      bnd   = (pos == 255);
      e_pwm = (pos < m_duty);
      m_k++;
    end else begin
      e_pwm = 0;
      m_k   = 0;
    end
    e_pt = bnd;
    e_ur = bnd && !m_full;
    m_prev_duty = m_duty;
    if (bnd) begin
      if (m_full) begin m_duty = m_pend; m_full = 0; end
      else if (m_ucnt < 255) m_ucnt++;
    end
    if (acc) begin m_pend = int'(sample_in); m_full = 1; end
    m_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm got %b exp 0", pwm_out); end
    n_tests++; if (period_tick !== 1'b0) begin n_fail++; $display("FAIL reset_pt got %b exp 0", period_tick); end
    n_tests++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", sample_ready); end
    @(negedge clk) rst = 0;
    model_reset();
    sample_in = 8'hC0; sample_valid = 1; en = 1;
    for (int i = 0; i < 600; i++) begin
      if (i == 540) begin sample_in = 8'h33; sample_valid = 1; end
      step();
      if (m_acc) sample_valid = 0;
      n_tests++; if (pwm_out !== e_pwm) begin n_fail++; $display("FAIL run_pwm t=%0t got %b exp %b", $time, pwm_out, e_pwm); end
      n_tests++; if (underrun !== e_ur) begin n_fail++; $display("FAIL run_ur t=%0t got %b exp %b", $time, underrun, e_ur); end
    end
    n_tests++; if (underrun_count !== 8'd1) begin n_fail++; $display("FAIL pre_reset_ucnt got %0d exp 1", underrun_count); end
    n_tests++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL pre_reset_ready got %b exp 0", sample_ready); end
    #2 rst = 1;
    #1;
    n_tests++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL async_rst_pwm got %b exp 0", pwm_out); end
    n_tests++; if (period_tick !== 1'b0) begin n_fail++; $display("FAIL async_rst_pt got %b exp 0", period_tick); end
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL async_rst_ur got %b exp 0", underrun); end
    n_tests++; if (underrun_count !== 8'd0) begin n_fail++; $display("FAIL async_rst_ucnt got %0d exp 0", underrun_count); end
    n_tests++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_ready got %b exp 1", sample_ready); end
    en = 0; sample_valid = 0;
    @(negedge clk) rst = 0;
    model_reset();
  endtask

  task automatic test_steady();
    int hi, p, npt;
    sample_in = 8'h40; sample_valid = 1; en = 0;
    step();
    n_tests++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL accept_while_disabled ready got %b exp 0", sample_ready); end
    en = 1; hi = 0; p = 0; npt = 0;
    for (int i = 0; i < 5 * 256; i++) begin
      step();
      n_tests++; if (pwm_out !== e_pwm) begin n_fail++; $display("FAIL steady_pwm t=%0t got %b exp %b", $time, pwm_out, e_pwm); end
      n_tests++; if (period_tick !== e_pt) begin n_fail++; $display("FAIL steady_pt t=%0t got %b exp %b", $time, period_tick, e_pt); end
      if (p >= 1) begin
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL steady_ur t=%0t got %b exp 0", $time, underrun); end
      end
      hi  += int'(pwm_out);
      npt += int'(period_tick);
      if (e_pt) begin
        if (p >= 1) begin
          n_tests++; if (hi !== 64) begin n_fail++; $display("FAIL steady_high_count period %0d got %0d exp 64", p, hi); end
        end
        p++; hi = 0;
      end
    end
    n_tests++; if (npt !== 5) begin n_fail++; $display("FAIL steady_period_ticks got %0d exp 5", npt); end
    sample_valid = 0;
  endtask

  task automatic test_extremes();
    logic [7:0] list [2];
    int hi, p, idx;
    list[0] = 8'h00; list[1] = 8'hFF;
    en = 0; step(); en = 1;
    hi = 0; p = 0; idx = 0;
    for (int i = 0; i < 4 * 256; i++) begin
      step();
      if (m_acc) sample_valid = 0;
      n_tests++; if (pwm_out !== e_pwm) begin n_fail++; $display("FAIL extreme_pwm t=%0t got %b exp %b", $time, pwm_out, e_pwm); end
      hi += int'(pwm_out);
      if (e_pt) begin
        if (p == 2) begin
          n_tests++; if (hi !== 0) begin n_fail++; $display("FAIL duty00_high_count got %0d exp 0", hi); end
        end
        if (p == 3) begin
          n_tests++; if (hi !== 255) begin n_fail++; $display("FAIL dutyFF_high_count got %0d exp 255", hi); end
        end
        p++; hi = 0;
        if (idx < 2) begin sample_in = list[idx]; sample_valid = 1; idx++; end
      end
    end
    sample_valid = 0;
  endtask

  task automatic test_back_to_back();
    int hi;
    bit found;
    en = 0; step(); en = 1;
    repeat (100) step();
    sample_in = 8'h10; sample_valid = 1;
    step();
    n_tests++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_first_accept ready got %b exp 0", sample_ready); end
    sample_in = 8'h20;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (period_tick) found = 1;
      else begin
        n_tests++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_ready t=%0t got %b exp 0", $time, sample_ready); end
      end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL b2b_boundary_timeout got none exp period_tick"); end
    n_tests++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_boundary got %b exp 1", sample_ready); end
    step();
    n_tests++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept ready got %b exp 0", sample_ready); end
    sample_valid = 0;
    hi = int'(pwm_out); found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(); hi += int'(pwm_out);
      if (period_tick) found = 1;
    end
    n_tests++; if (hi !== 16) begin n_fail++; $display("FAIL b2b_duty10_high_count got %0d exp 16", hi); end
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL b2b_no_underrun got %b exp 0", underrun); end
    hi = 0; found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(); hi += int'(pwm_out);
      if (period_tick) found = 1;
    end
    n_tests++; if (hi !== 32) begin n_fail++; $display("FAIL b2b_duty20_high_count got %0d exp 32", hi); end
    n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL b2b_final_underrun got %b exp 1", underrun); end
  endtask

  task automatic test_underrun();
    int hi;
    hi = 0;
    for (int i = 0; i < 3 * 256; i++) begin
      step();
      hi += int'(pwm_out);
      n_tests++; if (underrun !== e_ur) begin n_fail++; $display("FAIL ur_pulse t=%0t got %b exp %b", $time, underrun, e_ur); end
      n_tests++; if (underrun_count !== 8'(m_ucnt)) begin n_fail++; $display("FAIL ur_count t=%0t got %0d exp %0d", $time, underrun_count, m_ucnt); end
      if (e_pt) begin
        n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_at_boundary got %b exp 1", underrun); end
        n_tests++; if (hi !== 32) begin n_fail++; $display("FAIL ur_duty_retained high_count got %0d exp 32", hi); end
        hi = 0;
      end
    end
  endtask

  task automatic test_random();
    int hi;
    en = 0; step(); en = 1;
    hi = 0;
    for (int i = 0; i < 12 * 256; i++) begin
      if (!sample_valid && ($urandom_range(0, 299) == 0)) begin
        sample_in = 8'($urandom); sample_valid = 1;
      end
      step();
      if (m_acc) sample_valid = 0;
      n_tests++; if (pwm_out !== e_pwm) begin n_fail++; $display("FAIL rand_pwm t=%0t got %b exp %b", $time, pwm_out, e_pwm); end
      n_tests++; if (period_tick !== e_pt) begin n_fail++; $display("FAIL rand_pt t=%0t got %b exp %b", $time, period_tick, e_pt); end
      n_tests++; if (underrun !== e_ur) begin n_fail++; $display("FAIL rand_ur t=%0t got %b exp %b", $time, underrun, e_ur); end
      n_tests++; if (sample_ready !== !m_full) begin n_fail++; $display("FAIL rand_ready t=%0t got %b exp %b", $time, sample_ready, !m_full); end
      n_tests++; if (underrun_count !== 8'(m_ucnt)) begin n_fail++; $display("FAIL rand_ucnt t=%0t got %0d exp %0d", $time, underrun_count, m_ucnt); end
      hi += int'(pwm_out);
      if (e_pt) begin
        n_tests++; if (hi !== m_prev_duty) begin n_fail++; $display("FAIL rand_high_count got %0d exp %0d", hi, m_prev_duty); end
        hi = 0;
      end
    end
    sample_valid = 0; en = 0;
  endtask

  task automatic test_saturation();
    int pos, nur;
    bit exp_pwm, exp_ur;
    sinw = 4'h9; svw = 1;
    @(posedge clk); #1;
    n_tests++; if (srw !== 1'b0) begin n_fail++; $display("FAIL sat_accept ready got %b exp 0", srw); end
    svw = 0; enw = 1; nur = 0;
    for (int j = 0; j < 301 * 16; j++) begin
      @(posedge clk); #1;
      pos     = j % 16;
      exp_pwm = (j >= 16) && (pos < 9);
      exp_ur  = (pos == 15) && (j >= 16);
      n_tests++; if (pwmw !== exp_pwm) begin n_fail++; $display("FAIL sat_pwm j=%0d got %b exp %b", j, pwmw, exp_pwm); end
      n_tests++; if (urw !== exp_ur) begin n_fail++; $display("FAIL sat_ur j=%0d got %b exp %b", j, urw, exp_ur); end
      nur += int'(urw);
    end
    n_tests++; if (nur !== 300) begin n_fail++; $display("FAIL sat_pulse_count got %0d exp 300", nur); end
    n_tests++; if (ucw !== 8'd255) begin n_fail++; $display("FAIL sat_count got %0d exp 255", ucw); end
    enw = 0;
  endtask

  task automatic test_prescale();
    int pos, duty;
    bit exp_pwm, bnd;
    sin4 = 8'h80; sv4 = 1;
    @(posedge clk); #1;
    sv4 = 0; en4 = 1;
    for (int j = 0; j < 2348; j++) begin
      @(posedge clk); #1;
      pos     = (j / 4) % 256;
      duty    = (j < 1024) ? 0 : 128;
      exp_pwm = pos < duty;
      bnd     = (j % 1024) == 1023;
      n_tests++; if (pwm4 !== exp_pwm) begin n_fail++; $display("FAIL ps_pwm j=%0d got %b exp %b", j, pwm4, exp_pwm); end
      n_tests++; if (pt4 !== bnd) begin n_fail++; $display("FAIL ps_pt j=%0d got %b exp %b", j, pt4, bnd); end
      n_tests++; if (ur4 !== (bnd && j >= 1024)) begin n_fail++; $display("FAIL ps_ur j=%0d got %b exp %b", j, ur4, bnd && j >= 1024); end
    end
    en4 = 0;
    @(posedge clk); #1;
    n_tests++; if (pwm4 !== 1'b0) begin n_fail++; $display("FAIL ps_en_fall_pwm got %b exp 0", pwm4); end
    for (int j = 0; j < 50; j++) begin
      @(posedge clk); #1;
      n_tests++; if ({pwm4, pt4, ur4} !== 3'b000) begin n_fail++; $display("FAIL ps_disabled j=%0d got %b exp 000", j, {pwm4, pt4, ur4}); end
    end
    en4 = 1;
    for (int j = 0; j < 1100; j++) begin
      @(posedge clk); #1;
      exp_pwm = ((j / 4) % 256) < 128;
      bnd     = (j == 1023);
      n_tests++; if (pwm4 !== exp_pwm) begin n_fail++; $display("FAIL ps_restart_pwm j=%0d got %b exp %b", j, pwm4, exp_pwm); end
      n_tests++; if (pt4 !== bnd) begin n_fail++; $display("FAIL ps_restart_pt j=%0d got %b exp %b", j, pt4, bnd); end
      n_tests++; if (ur4 !== bnd) begin n_fail++; $display("FAIL ps_restart_ur j=%0d got %b exp %b", j, ur4, bnd); end
    end
    n_tests++; if (uc4 !== 8'd2) begin n_fail++; $display("FAIL ps_ucnt got %0d exp 2", uc4); end
    en4 = 0;
  endtask

  initial begin
    clk = 0; rst = 1;
    en = 0; sample_valid = 0; sample_in = '0;
    en4 = 0; sv4 = 0; sin4 = '0;
    enw = 0; svw = 0; sinw = '0;
    n_tests = 0; n_fail = 0;
    model_reset();
    test_reset();
    test_steady();
    test_extremes();
    test_back_to_back();
    test_underrun();
    test_random();
    test_saturation();
    test_prescale();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
